// File: rtl/gpio_bank.sv
// Parameterised GPIO bank: per-port OUT/DIR registers with SET/CLR/TGL
// aliases, 2-flop input synchronizers, edge-detect interrupts with
// write-1-to-clear pending bits, and a registered read-data path.
module gpio_bank #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned PORTS = 2,
  parameter logic [15:0] BASE  = 16'h0000
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic                   io_rd,
  input  logic                   io_wr,
  input  logic [15:0]            io_addr,
  input  logic [31:0]            io_wdata,
  output logic [31:0]            io_rdata,
  output logic [PORTS*WIDTH-1:0] pin_o,
  output logic [PORTS*WIDTH-1:0] pin_oe,
  input  logic [PORTS*WIDTH-1:0] pin_i,
  output logic                   irq
);

  localparam int unsigned N = PORTS * WIDTH;

  localparam logic [5:0] OFF_OUT  = 6'h00;
  localparam logic [5:0] OFF_DIR  = 6'h04;
  localparam logic [5:0] OFF_IN   = 6'h08;
  localparam logic [5:0] OFF_SET  = 6'h0C;
  localparam logic [5:0] OFF_CLR  = 6'h10;
  localparam logic [5:0] OFF_TGL  = 6'h14;
  localparam logic [5:0] OFF_RISE = 6'h18;
  localparam logic [5:0] OFF_FALL = 6'h1C;
  localparam logic [5:0] OFF_PEND = 6'h20;

  // All ports are packed side by side: port p lives at [p*WIDTH +: WIDTH].
  logic [N-1:0] out_q,  out_d;
  logic [N-1:0] dir_q,  dir_d;
  logic [N-1:0] ren_q,  ren_d;
  logic [N-1:0] fen_q,  fen_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] s1_q, s2_q, prev_q;
  logic [31:0]  rdata_q, rdata_d;
  logic         irq_q;

  logic [15:0]      rel_addr;
  logic [9:0]       win;
  logic [5:0]       off;
  logic             hit;
  logic [WIDTH-1:0] wd;
  logic [N-1:0]     edge_set;
  logic             unused_wdata;

  // Window-relative address: addresses below BASE wrap high and miss.
  assign rel_addr     = io_addr - BASE;
  assign win          = rel_addr[15:6];
  assign off          = rel_addr[5:0];
  assign hit          = (win < 10'(PORTS));
  assign wd           = io_wdata[WIDTH-1:0];
  assign unused_wdata = ^io_wdata;

  // Qualified edges seen this cycle, from the synchronized pin and its history.
  assign edge_set = ((s2_q & ~prev_q) & ren_q) | ((~s2_q & prev_q) & fen_q);

  // Bus decode: next-state of every software register plus read data mux.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    out_d   = out_q;
    dir_d   = dir_q;
    ren_d   = ren_q;
    fen_d   = fen_q;
    pend_d  = pend_q | edge_set;
    rdata_d = rdata_q;
    if (io_rd) rdata_d = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (hit && (win == 10'(p))) begin
        if (io_wr) begin
          case (off)
            OFF_OUT:  out_d[p*WIDTH +: WIDTH] = wd;
            OFF_DIR:  dir_d[p*WIDTH +: WIDTH] = wd;
            OFF_SET:  out_d[p*WIDTH +: WIDTH] = out_q[p*WIDTH +: WIDTH] | wd;
            OFF_CLR:  out_d[p*WIDTH +: WIDTH] = out_q[p*WIDTH +: WIDTH] & ~wd;
            OFF_TGL:  out_d[p*WIDTH +: WIDTH] = out_q[p*WIDTH +: WIDTH] ^ wd;
            OFF_RISE: ren_d[p*WIDTH +: WIDTH] = wd;
            OFF_FALL: fen_d[p*WIDTH +: WIDTH] = wd;
            // A fresh edge overrides a simultaneous clear.
            OFF_PEND: pend_d[p*WIDTH +: WIDTH] = (pend_q[p*WIDTH +: WIDTH] & ~wd)
                                                | edge_set[p*WIDTH +: WIDTH];
            default: ;
          endcase
        end
        // Reads always see the pre-write register values.
        if (io_rd) begin
          case (off)
            OFF_OUT:  rdata_d = 32'(out_q[p*WIDTH +: WIDTH]);
            OFF_DIR:  rdata_d = 32'(dir_q[p*WIDTH +: WIDTH]);
            OFF_IN:   rdata_d = 32'(s2_q[p*WIDTH +: WIDTH]);
            OFF_RISE: rdata_d = 32'(ren_q[p*WIDTH +: WIDTH]);
            OFF_FALL: rdata_d = 32'(fen_q[p*WIDTH +: WIDTH]);
            OFF_PEND: rdata_d = 32'(pend_q[p*WIDTH +: WIDTH]);
            default:  rdata_d = '0;
          endcase
        end
      end
    end
  end

  // State update, synchronizer chain and registered interrupt.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block only.
    if (!resetq) begin
      out_q   <= '0;
      dir_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      pend_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_q   <= out_d;
      dir_q   <= dir_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      pend_q  <= pend_d;
      s1_q    <= pin_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      rdata_q <= rdata_d;
      irq_q   <= |pend_q;
    end
  end

  assign pin_o    = out_q;
  assign pin_oe   = dir_q;
  assign io_rdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios followed by random
// bus/pin traffic, all compared each cycle against a behavioural model.
module tb_gpio_bank;

  localparam int W = 28;
  localparam int P = 2;
  localparam int N = W * P;
  localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

  logic          clk = 1'b0;
  logic          resetq = 1'b0;
  logic          io_rd = 1'b0;
  logic          io_wr = 1'b0;
  logic [15:0]   io_addr = '0;
  logic [31:0]   io_wdata = '0;
  logic [31:0]   io_rdata;
  logic [N-1:0]  pin_o;
  logic [N-1:0]  pin_oe;
  logic [N-1:0]  pin_i = '0;
  logic          irq;

  int checks = 0;
  int failures = 0;

  gpio_bank #(.WIDTH(W), .PORTS(P), .BASE(16'h0000)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .pin_o    (pin_o),
    .pin_oe   (pin_oe),
    .pin_i    (pin_i),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-port register values and the pin values sampled
  // at the last three clock edges (h0 newest).
  bit [31:0]  m_out[P], m_dir[P], m_ren[P], m_fen[P], m_pend[P];
  bit [31:0]  m_rdata;
  bit         m_irq;
  bit [N-1:0] h0, h1, h2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] port_bits(input bit [N-1:0] v, input int p);
    return 32'(v >> (p * W)) & MASK;
  endfunction

  function automatic bit [N-1:0] pack(input bit [31:0] a[P]);
    bit [N-1:0] v = '0;
    for (int p = 0; p < P; p++) v |= N'(a[p] & MASK) << (p * W);
    return v;
  endfunction

  // One clock: evaluate the model on the pre-edge inputs, step the DUT,
  // commit the model and compare every output.
  task automatic cycle();
    bit [31:0]  n_out[P], n_dir[P], n_ren[P], n_fen[P], n_pend[P], edges[P];
    bit [31:0]  n_rdata, d, rise, fall;
    bit         n_irq;
    bit [N-1:0] n_h0, n_h1, n_h2;
    int         port, off;
    bit         hit;

    n_out = m_out; n_dir = m_dir; n_ren = m_ren; n_fen = m_fen;
    port = int'(io_addr) / 64;
    off  = int'(io_addr) % 64;
    hit  = port < P;
    d    = io_wdata & MASK;

    n_irq = 1'b0;
    for (int p = 0; p < P; p++) begin
      if (m_pend[p] != 0) n_irq = 1'b1;
      rise     = port_bits(h1, p) & ~port_bits(h2, p) & MASK;
      fall     = ~port_bits(h1, p) & port_bits(h2, p) & MASK;
      edges[p] = (rise & m_ren[p]) | (fall & m_fen[p]);
      n_pend[p] = m_pend[p] | edges[p];
    end

    n_rdata = m_rdata;
    if (io_rd) begin
      n_rdata = 0;
      if (hit) begin
        case (off)
          'h00: n_rdata = m_out[port];
          'h04: n_rdata = m_dir[port];
          'h08: n_rdata = port_bits(h1, port);
          'h18: n_rdata = m_ren[port];
          'h1C: n_rdata = m_fen[port];
          'h20: n_rdata = m_pend[port];
          default: n_rdata = 0;
        endcase
      end
    end

    if (io_wr && hit) begin
      case (off)
        'h00: n_out[port] = d;
        'h04: n_dir[port] = d;
        'h0C: n_out[port] = m_out[port] | d;
        'h10: n_out[port] = m_out[port] & ~d;
        'h14: n_out[port] = m_out[port] ^ d;
        'h18: n_ren[port] = d;
        'h1C: n_fen[port] = d;
        'h20: n_pend[port] = (m_pend[port] & ~d) | edges[port];
        default: ;
      endcase
    end

    n_h2 = h1; n_h1 = h0; n_h0 = pin_i;
    if (!resetq) begin
      for (int p = 0; p < P; p++) begin
        n_out[p] = 0; n_dir[p] = 0; n_ren[p] = 0; n_fen[p] = 0; n_pend[p] = 0;
      end
      n_rdata = 0; n_irq = 1'b0;
      n_h0 = '0; n_h1 = '0; n_h2 = '0;
    end

    @(posedge clk);
    #1;
    m_out = n_out; m_dir = n_dir; m_ren = n_ren; m_fen = n_fen; m_pend = n_pend;
    m_rdata = n_rdata; m_irq = n_irq;
    h0 = n_h0; h1 = n_h1; h2 = n_h2;

    check("pin_o",    64'(pin_o),    64'(pack(m_out)));
    check("pin_oe",   64'(pin_oe),   64'(pack(m_dir)));
    check("irq",      64'(irq),      64'(m_irq));
    check("io_rdata", 64'(io_rdata), 64'(m_rdata));
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] v);
    io_wr = 1'b1; io_addr = a; io_wdata = v;
    cycle();
    io_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    io_rd = 1'b1; io_addr = a;
    cycle();
    io_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int a;

    // Reset and reset-state checks.
    resetq = 1'b0;
    idle(2);
    resetq = 1'b1;
    check("reset_pin_o",  64'(pin_o),    64'd0);
    check("reset_pin_oe", 64'(pin_oe),   64'd0);
    check("reset_irq",    64'(irq),      64'd0);
    check("reset_rdata",  64'(io_rdata), 64'd0);

    // SET/CLR/TGL sequence on port 0.
    bus_wr(16'h0000, 32'h0F);
    bus_wr(16'h0004, 32'hFF);
    bus_wr(16'h000C, 32'h30);
    bus_wr(16'h0010, 32'h01);
    bus_wr(16'h0014, 32'h81);
    bus_rd(16'h0000);
    check("out_after_set_clr_tgl", 64'(io_rdata), 64'h0000_00BF);
    check("pin_oe_low_byte", 64'(pin_oe[7:0]), 64'hFF);

    // Input synchronizer latency on port 1, upper bits read as zero.
    pin_i[W + 3] = 1'b1;
    idle(2);
    bus_rd(16'h0048);
    check("in_port1", 64'(io_rdata), 64'h8);
    check("in_port1_upper_zero", 64'(io_rdata[31:28]), 64'h0);

    // Rising-edge interrupt and write-1-to-clear.
    bus_wr(16'h0018, 32'h1);
    pin_i[0] = 1'b1;
    idle(4);
    check("irq_after_rise", 64'(irq), 64'd1);
    bus_rd(16'h0020);
    check("pend_after_rise", 64'(io_rdata), 64'h1);
    bus_wr(16'h0020, 32'h1);
    check("irq_one_cycle_after_clear", 64'(irq), 64'd1);
    cycle();
    check("irq_cleared", 64'(irq), 64'd0);

    // Re-arm pending, then clear it in the very cycle a new edge lands.
    pin_i[0] = 1'b0; idle(4);
    pin_i[0] = 1'b1; idle(4);
    pin_i[0] = 1'b0; idle(4);
    check("pend_rearmed_irq", 64'(irq), 64'd1);
    pin_i[0] = 1'b1;
    idle(2);
    bus_wr(16'h0020, 32'h1);
    bus_rd(16'h0020);
    check("pend_edge_wins", 64'(io_rdata), 64'h1);
    check("irq_edge_wins", 64'(irq), 64'd1);

    // Port index beyond PORTS is ignored and reads zero.
    bus_wr(16'h0080, 32'hFFFF_FFFF);
    bus_rd(16'h0080);
    check("oob_read_zero", 64'(io_rdata), 64'h0);
    bus_rd(16'h0000);
    check("oob_no_effect_out", 64'(io_rdata), 64'h0000_00BF);

    // Random bus and pin traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      io_rd = 1'($urandom_range(0, 1));
      io_wr = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) a = a & ~3;
      io_addr  = 16'(a);
      io_wdata = $urandom;
      if ($urandom_range(0, 2) == 0) pin_i[$urandom_range(0, N - 1)] ^= 1'b1;
      resetq = ($urandom_range(0, 99) != 0);
      cycle();
    end
    io_rd = 1'b0; io_wr = 1'b0; resetq = 1'b1;
    idle(2);

    // Reset with all pins high: no pending bits and no irq throughout.
    pin_i = '1;
    resetq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("irq_in_reset", 64'(irq), 64'd0);
    end
    resetq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("irq_after_reset", 64'(irq), 64'd0);
    end
    bus_rd(16'h0020);
    check("pend0_after_reset", 64'(io_rdata), 64'h0);
    bus_rd(16'h0060);
    check("pend1_after_reset", 64'(io_rdata), 64'h0);
    bus_rd(16'h0008);
    check("in0_all_ones", 64'(io_rdata), 64'(MASK));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
